// File: rtl/rtype_instruction_encoder_if.sv
// ============================================================================
//  Module   : rtype_instruction_encoder_if
//  Brief    : Request/response stream bundle for the R-type instruction encoder.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rtype_instruction_encoder_if #(
  parameter int CNT_W = 16
);
  logic             inValid;
  logic             inReady;
  logic [3:0]       inOpALU;
  logic [4:0]       inRd;
  logic [4:0]       inRs1;
  logic [4:0]       inRs2;
  logic             outValid;
  logic             outReady;
  logic [31:0]      outInstr;
  logic             errPulse;
  logic [CNT_W-1:0] instrCount;
  logic [CNT_W-1:0] errCount;

  modport master (
    output inValid, inOpALU, inRd, inRs1, inRs2, outReady,
    input  inReady, outValid, outInstr, errPulse, instrCount, errCount
  );

  modport slave (
    input  inValid, inOpALU, inRd, inRs1, inRs2, outReady,
    output inReady, outValid, outInstr, errPulse, instrCount, errCount
  );
endinterface

`default_nettype wire

// File: rtl/rtype_instruction_encoder.sv
// ============================================================================
//  Module   : rtype_instruction_encoder
//  Brief    : Encodes ALU micro-op requests into RV32I R-type words, 2-deep FIFO.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rtype_instruction_encoder #(
  parameter int CNT_W = 16
) (
  input  wire logic                   clk,
  input  wire logic                   rstN,
  rtype_instruction_encoder_if.slave  bus
);

  localparam logic [6:0] C_OPCODE_OP = 7'b0110011;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

  occ_t             r_state;
  occ_t             w_state_nxt;
  logic [31:0]      r_head;
  logic [31:0]      r_tail;
  logic [31:0]      w_head_nxt;
  logic [31:0]      w_tail_nxt;
  logic             r_err_pulse;
  logic [CNT_W-1:0] r_instr_count;
  logic [CNT_W-1:0] r_err_count;

  logic             w_legal;
  logic [2:0]       w_fun3;
  logic [6:0]       w_fun7;
  logic [31:0]      w_word;
  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_accept;
  logic             w_push;
  logic             w_drop;
  logic             w_pop;

  // Inverse of the decoder's opALU table.
  always_comb begin
    w_legal = 1'b1;
    w_fun3  = 3'b000;
    w_fun7  = 7'h00;
    case (bus.inOpALU)
      4'd0:    w_fun3 = 3'b000;
      4'd1:    begin w_fun3 = 3'b000; w_fun7 = 7'h20; end
      4'd2:    w_fun3 = 3'b111;
      4'd3:    w_fun3 = 3'b110;
      4'd4:    w_fun3 = 3'b100;
      4'd5:    w_fun3 = 3'b001;
      4'd6:    w_fun3 = 3'b101;
      4'd7:    begin w_fun3 = 3'b101; w_fun7 = 7'h20; end
      4'd8:    w_fun3 = 3'b010;
      4'd9:    w_fun3 = 3'b011;
      default: w_legal = 1'b0;
    endcase
  end

  assign w_word      = {w_fun7, bus.inRs2, bus.inRs1, w_fun3, bus.inRd, C_OPCODE_OP};
  assign w_in_ready  = (r_state != FULL);
  assign w_out_valid = (r_state != EMPTY);
  assign w_accept    = bus.inValid & w_in_ready;
  assign w_push      = w_accept & w_legal;
  assign w_drop      = w_accept & ~w_legal;
  assign w_pop       = w_out_valid & bus.outReady;

  // The head register doubles as outInstr, so it simply keeps its value when
  // the FIFO drains, which gives the hold-last-word behaviour for free.
  always_comb begin
    w_state_nxt = r_state;
    w_head_nxt  = r_head;
    w_tail_nxt  = r_tail;
    case (r_state)
      EMPTY: begin
        if (w_push) begin
          w_head_nxt  = w_word;
          w_state_nxt = ONE;
        end
      end
      ONE: begin
        case ({w_push, w_pop})
          2'b10: begin
            w_tail_nxt  = w_word;
            w_state_nxt = FULL;
          end
          2'b01:   w_state_nxt = EMPTY;
          2'b11:   w_head_nxt  = w_word;
          default: w_state_nxt = ONE;
        endcase
      end
      FULL: begin
        if (w_pop) begin
          w_head_nxt  = r_tail;
          w_state_nxt = ONE;
        end
      end
      default: w_state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state <= EMPTY;
      r_head  <= 32'h0;
      r_tail  <= 32'h0;
    end else begin
      r_state <= w_state_nxt;
      r_head  <= w_head_nxt;
      r_tail  <= w_tail_nxt;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_err_pulse   <= 1'b0;
      r_instr_count <= '0;
      r_err_count   <= '0;
    end else begin
      r_err_pulse <= w_drop;
      if (w_pop) begin
        r_instr_count <= r_instr_count + 1'b1;
      end
      if (w_drop) begin
        r_err_count <= r_err_count + 1'b1;
      end
    end
  end

  assign bus.inReady    = w_in_ready;
  assign bus.outValid   = w_out_valid;
  assign bus.outInstr   = r_head;
  assign bus.errPulse   = r_err_pulse;
  assign bus.instrCount = r_instr_count;
  assign bus.errCount   = r_err_count;

endmodule

`default_nettype wire
